tetris_board_renderer: RTL and testbench

//  Pixel source feeding vga_screen: converts (on_screen, screen_x, screen_y) into the RGB565 screen_pixel of the

---
 rtl/tetris_board_renderer.sv | 153 +++++++++++++++
 tb/tb_tetris_board_renderer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_board_renderer.sv
// Tetris playfield pixel source: double-buffered 10x20 board, registered RGB565 output.
// Optional grid-line drawing of empty cells is enabled by defining BOARD_GRID_EN.
module tetris_board_renderer #(
  parameter int          BOARD_X      = 352,
  parameter int          BOARD_Y      = 64,
  parameter int          CELL_LOG2    = 5,
  parameter int          BORDER_W     = 4,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter logic [15:0] BORDER_COLOR = 16'hFFFF
`ifdef BOARD_GRID_EN
  ,
  parameter logic [15:0] GRID_COLOR   = 16'h2104
`endif
) (
  input  logic        vga_clk,
  input  logic        vga_rst,
  input  logic        on_screen,
  input  logic [10:0] screen_x,
  input  logic [10:0] screen_y,
  input  logic        vga_vsync,
  output logic [15:0] screen_pixel,
  input  logic        wr_en,
  input  logic [3:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [2:0]  wr_color,
  input  logic        commit_req,
  output logic        commit_busy,
  output logic        frame_tick
);

  localparam int Cols  = 10;
  localparam int Rows  = 20;
  localparam int AreaW = Cols << CELL_LOG2;
  localparam int AreaH = Rows << CELL_LOG2;

  localparam logic signed [11:0] Zero    = 12'sd0;
  localparam logic signed [11:0] AreaWS  = 12'(AreaW);
  localparam logic signed [11:0] AreaHS  = 12'(AreaH);
  localparam logic signed [11:0] FrameLo = 12'(-BORDER_W);
  localparam logic signed [11:0] FrameXHi = 12'(AreaW + BORDER_W);
  localparam logic signed [11:0] FrameYHi = 12'(AreaH + BORDER_W);

  typedef enum logic [0:0] {StIdle, StPend} state_e;

  state_e     state_q, state_d;
  logic       vsync_q;
  logic       boundary;
  logic       copy;
  logic [2:0] back_q  [Rows][Cols];
  logic [2:0] front_q [Rows][Cols];

  assign boundary    = vsync_q && !vga_vsync;
  assign commit_busy = (state_q == StPend);

  // A request arriving on a boundary cycle in idle waits for the next boundary.
  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    case (state_q)
      StIdle: if (commit_req) state_d = StPend;
      StPend: begin
        if (boundary) begin
          copy    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      state_q    <= StIdle;
      vsync_q    <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= vga_vsync;
      frame_tick <= boundary;
    end
  end

  // Copy samples back before this cycle's write, so a coincident write lands in back only.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      for (int r = 0; r < Rows; r++) begin
        for (int c = 0; c < Cols; c++) begin
          back_q[r][c]  <= 3'd0;
          front_q[r][c] <= 3'd0;
        end
      end
    end else begin
      if (wr_en && (wr_col < 4'(Cols)) && (wr_row < 5'(Rows))) begin
        back_q[wr_row][wr_col] <= wr_color;
      end
      if (copy) begin
        front_q <= back_q;
      end
    end
  end

  function automatic logic [15:0] palette(input logic [2:0] code);
    case (code)
      3'd1:    palette = 16'h07FF;
      3'd2:    palette = 16'hFFE0;
      3'd3:    palette = 16'hF81F;
      3'd4:    palette = 16'h07E0;
      3'd5:    palette = 16'hF800;
      3'd6:    palette = 16'h001F;
      3'd7:    palette = 16'hFD20;
      default: palette = BG_COLOR;
    endcase
  endfunction

  logic signed [11:0] dx, dy;
  logic               in_area, in_frame;
  logic [3:0]         col;
  logic [4:0]         row;
  logic [2:0]         code;
  logic [15:0]        pix;

  always_comb begin
    dx       = 12'({1'b0, screen_x}) - 12'(BOARD_X);
    dy       = 12'({1'b0, screen_y}) - 12'(BOARD_Y);
    col      = dx[CELL_LOG2 +: 4];
    row      = dy[CELL_LOG2 +: 5];
    in_area  = (dx >= Zero) && (dx < AreaWS) && (dy >= Zero) && (dy < AreaHS);
    in_frame = (dx >= FrameLo) && (dx < FrameXHi) && (dy >= FrameLo) && (dy < FrameYHi);
    code     = 3'd0;
    if (in_area) code = front_q[row][col];
    pix = BG_COLOR;
    if (in_area) begin
      pix = palette(code);
`ifdef BOARD_GRID_EN
      if ((code == 3'd0) &&
          ((dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0))) begin
        pix = GRID_COLOR;
      end
`endif
    end else if (in_frame) begin
      pix = BORDER_COLOR;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      screen_pixel <= 16'h0000;
    end else begin
      screen_pixel <= on_screen ? pix : 16'h0000;
    end
  end

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Directed, table-driven bench for tetris_board_renderer.
module tb_tetris_board_renderer;

`ifdef BOARD_GRID_EN
  localparam logic [15:0] GridExp = 16'h2104;
`else
  localparam logic [15:0] GridExp = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        on_screen;
  logic [10:0] screen_x, screen_y;
  logic        vsync;
  logic [15:0] screen_pixel;
  logic        wr_en;
  logic [3:0]  wr_col;
  logic [4:0]  wr_row;
  logic [2:0]  wr_color;
  logic        commit_req;
  logic        commit_busy;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tetris_board_renderer dut (
    .vga_clk     (clk),
    .vga_rst     (rst),
    .on_screen   (on_screen),
    .screen_x    (screen_x),
    .screen_y    (screen_y),
    .vga_vsync   (vsync),
    .screen_pixel(screen_pixel),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_color    (wr_color),
    .commit_req  (commit_req),
    .commit_busy (commit_busy),
    .frame_tick  (frame_tick)
  );

  typedef struct {
    string       name;
    logic        on;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic on, input int x, input int y,
                     input logic [15:0] e);
    vec_t v;
    v.name = n; v.on = on; v.x = 11'(x); v.y = 11'(y); v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input string n, input logic on, input int x, input int y,
                       input logic [15:0] e);
    on_screen = on; screen_x = 11'(x); screen_y = 11'(y);
    tick();
    check(n, screen_pixel, e);
  endtask

  task automatic write(input int c, input int r, input int code);
    wr_en = 1'b1; wr_col = 4'(c); wr_row = 5'(r); wr_color = 3'(code);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic vsync_fall(input string n);
    vsync = 1'b0;
    tick();
    check({n, "_tick"}, 16'(frame_tick), 16'd1);
    vsync = 1'b1;
    tick();
    check({n, "_tick_low"}, 16'(frame_tick), 16'd0);
  endtask

  task automatic commit_flip(input string n);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    check({n, "_busy"}, 16'(commit_busy), 16'd1);
    vsync_fall(n);
    check({n, "_idle"}, 16'(commit_busy), 16'd0);
  endtask

  // Cell centre coordinates
  function automatic int cx(input int c); return 352 + 32 * c + 16; endfunction
  function automatic int cy(input int r); return 64 + 32 * r + 16; endfunction

  initial begin
    rst = 1'b1; on_screen = 1'b0; screen_x = '0; screen_y = '0; vsync = 1'b1;
    wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_color = '0; commit_req = 1'b0;

    repeat (3) tick();
    check("rst_pixel", screen_pixel, 16'h0000);
    check("rst_busy", 16'(commit_busy), 16'd0);
    check("rst_tick", 16'(frame_tick), 16'd0);
    rst = 1'b0;

    pixel("bg_after_reset", 1'b1, 360, 100, 16'h0000);
    check("busy_after_reset", 16'(commit_busy), 16'd0);
    pixel("grid_empty", 1'b1, 384, 64, GridExp);

    // Back buffer write is invisible until committed.
    write(0, 0, 2);
    pixel("uncommitted", 1'b1, 360, 70, 16'h0000);
    commit_flip("c1");
    pixel("committed_yellow", 1'b1, 360, 70, 16'hFFE0);

    // Request coinciding with a boundary waits for the next one; a second request merges.
    write(3, 0, 5);
    commit_req = 1'b1; vsync = 1'b0;
    tick();
    commit_req = 1'b0; vsync = 1'b1;
    check("coinc_tick", 16'(frame_tick), 16'd1);
    check("coinc_busy", 16'(commit_busy), 16'd1);
    pixel("coinc_no_copy", 1'b1, cx(3), cy(0), 16'h0000);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    check("merged_busy", 16'(commit_busy), 16'd1);
    vsync_fall("coinc2");
    check("coinc_done", 16'(commit_busy), 16'd0);
    pixel("coinc_copied", 1'b1, cx(3), cy(0), 16'hF800);
    vsync_fall("extra");
    check("merged_no_repend", 16'(commit_busy), 16'd0);

    // Out-of-range writes are dropped.
    write(10, 0, 1);
    write(0, 20, 1);
    write(15, 31, 1);
    commit_flip("c_oor");
    pixel("oor_cell00", 1'b1, 360, 70, 16'hFFE0);
    pixel("oor_cell10", 1'b1, cx(1), cy(0), 16'h0000);
    pixel("oor_cell019", 1'b1, cx(0), cy(19), 16'h0000);
    pixel("oor_cell90", 1'b1, cx(9), cy(0), 16'h0000);

    // Write during the copy cycle: front takes the old back value.
    write(2, 0, 3);
    commit_flip("c_pre");
    pixel("pre_magenta", 1'b1, cx(2), cy(0), 16'hF81F);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    wr_en = 1'b1; wr_col = 4'd2; wr_row = 5'd0; wr_color = 3'd6; vsync = 1'b0;
    tick();
    wr_en = 1'b0; vsync = 1'b1;
    check("wrcopy_idle", 16'(commit_busy), 16'd0);
    pixel("wrcopy_front_old", 1'b1, cx(2), cy(0), 16'hF81F);
    commit_flip("c_post");
    pixel("wrcopy_back_new", 1'b1, cx(2), cy(0), 16'h001F);

    // Fill a palette row and far corner, then sweep the table.
    for (int i = 0; i < 7; i++) write(i, 5, i + 1);
    write(9, 19, 7);
    write(1, 0, 7);
    commit_flip("c_pal");

    add("pal1", 1'b1, cx(0), cy(5), 16'h07FF);
    add("pal2", 1'b1, cx(1), cy(5), 16'hFFE0);
    add("pal3", 1'b1, cx(2), cy(5), 16'hF81F);
    add("pal4", 1'b1, cx(3), cy(5), 16'h07E0);
    add("pal5", 1'b1, cx(4), cy(5), 16'hF800);
    add("pal6", 1'b1, cx(5), cy(5), 16'h001F);
    add("pal7", 1'b1, cx(6), cy(5), 16'hFD20);
    add("pal_empty", 1'b1, cx(7), cy(5), 16'h0000);
    add("far_corner", 1'b1, 671, 703, 16'hFD20);
    add("grid_pix_code7", 1'b1, 384, 64, 16'hFD20);
    add("border_x350", 1'b1, 350, 300, 16'hFFFF);
    add("border_x348", 1'b1, 348, 300, 16'hFFFF);
    add("outside_x347", 1'b1, 347, 300, 16'h0000);
    add("border_dx320", 1'b1, 672, 300, 16'hFFFF);
    add("border_dx323", 1'b1, 675, 300, 16'hFFFF);
    add("outside_dx324", 1'b1, 676, 300, 16'h0000);
    add("border_dy_m4", 1'b1, 400, 60, 16'hFFFF);
    add("outside_dy_m5", 1'b1, 400, 59, 16'h0000);
    add("border_dy640", 1'b1, 400, 704, 16'hFFFF);
    add("border_dy643", 1'b1, 400, 707, 16'hFFFF);
    add("outside_dy644", 1'b1, 400, 708, 16'h0000);
    add("border_corner", 1'b1, 348, 60, 16'hFFFF);
    add("off_screen_cell", 1'b0, cx(6), cy(5), 16'h0000);
    add("off_screen_border", 1'b0, 350, 300, 16'h0000);
    add("far_outside", 1'b1, 100, 100, 16'h0000);

    foreach (vecs[i]) pixel(vecs[i].name, vecs[i].on, vecs[i].x, vecs[i].y, vecs[i].exp);

    // Reset while a commit is pending drops it and clears both buffers.
    write(4, 0, 4);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    check("midpend_busy", 16'(commit_busy), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 16'(commit_busy), 16'd0);
    vsync_fall("midrst");
    check("midrst_still_idle", 16'(commit_busy), 16'd0);
    pixel("midrst_front_clear", 1'b1, 360, 70, 16'h0000);
    commit_flip("c_clear");
    pixel("midrst_back_clear", 1'b1, cx(4), cy(0), 16'h0000);
    pixel("midrst_pal_clear", 1'b1, cx(0), cy(5), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
